pll_lock_sequencer: RTL

Power-up and lock-supervision controller for the iCE40 `SB_PLL40_PAD` clock generator (100 MHz in, 60 MHz out).
- Runs on the 100 MHz reference clock and drives the PLL's active-low reset.
- Qualifies the PLL `LOCK` output and releases the system reset only after lock has been stable for a set time.
- On lock loss it re-enters the reset sequence; on repeated lock timeouts it retries a bounded number of times, then latches a fault.

---
 rtl/pll_lock_sequencer_if.sv | 31 +++
 rtl/pll_lock_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer_if.sv
// Handshake bundle between the PLL lock sequencer and its environment.
// The slave side is the sequencer itself; the master side drives lock/relock.
interface pll_lock_sequencer_if;
   logic       PLL_LOCK;
   logic       FORCE_RELOCK;
   logic       PLL_RESETB;
   logic       SYS_RESETN;
   logic       LOCKED;
   logic       FAULT;
   logic [3:0] RETRY_COUNT;

   modport master (
      output PLL_LOCK,
      output FORCE_RELOCK,
      input  PLL_RESETB,
      input  SYS_RESETN,
      input  LOCKED,
      input  FAULT,
      input  RETRY_COUNT
   );

   modport slave (
      input  PLL_LOCK,
      input  FORCE_RELOCK,
      output PLL_RESETB,
      output SYS_RESETN,
      output LOCKED,
      output FAULT,
      output RETRY_COUNT
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Power-up and lock supervision for the iCE40 PLL: holds the PLL in reset,
// qualifies LOCK, releases system reset, retries on timeout, latches FAULT.
module pll_lock_sequencer #(
   parameter int RST_HOLD_CYCLES     = 100,
   parameter int LOCK_TIMEOUT_CYCLES = 10000,
   parameter int LOCK_STABLE_CYCLES  = 64,
   parameter int MAX_RETRIES         = 3
) (
   input  logic                 CLK,
   input  logic                 RESET,
   pll_lock_sequencer_if.slave  bus
);

   localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
   localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);

   localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [SW-1:0] STB_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_HOLD,
      S_WAIT,
      S_STABLE,
      S_RUN,
      S_FAULT
   } state_t;

   state_t        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [SW-1:0] stab_q, stab_d;
   logic [3:0]    retry_q, retry_d;
   logic [1:0]    sync_q;
   logic          resetb_q, resetb_d;
   logic          run_q, run_d;
   logic          fault_q, fault_d;
   logic          lock_s;

   assign lock_s = sync_q[1];

   // LOCK is meaningless while the PLL sits in reset, so the synchronizer
   // is flushed then and lock qualification starts fresh on release.
   always_ff @(posedge CLK) begin
      if (!RESET || !resetb_q) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], bus.PLL_LOCK};
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q  <= S_HOLD;
         hold_q   <= '0;
         tmo_q    <= '0;
         stab_q   <= '0;
         retry_q  <= '0;
         resetb_q <= 1'b0;
         run_q    <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         tmo_q    <= tmo_d;
         stab_q   <= stab_d;
         retry_q  <= retry_d;
         resetb_q <= resetb_d;
         run_q    <= run_d;
         fault_q  <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      tmo_d   = tmo_q;
      stab_d  = stab_q;
      retry_d = retry_q;
      if (bus.FORCE_RELOCK) begin
         state_d = S_HOLD;
         hold_d  = '0;
         stab_d  = '0;
         retry_d = '0;
      end else begin
         unique case (state_q)
            S_HOLD: begin
               if (hold_q == HOLD_LAST) begin
                  state_d = S_WAIT;
                  hold_d  = '0;
                  tmo_d   = '0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            S_WAIT, S_STABLE: begin
               if (tmo_q == TMO_LAST) begin
                  hold_d = '0;
                  stab_d = '0;
                  if (retry_q < RETRY_MAX) begin
                     retry_d = retry_q + 1'b1;
                     state_d = S_HOLD;
                  end else begin
                     state_d = S_FAULT;
                  end
               end else begin
                  tmo_d = tmo_q + 1'b1;
                  if (!lock_s) begin
                     state_d = S_WAIT;
                     stab_d  = '0;
                  end else if (state_q == S_WAIT) begin
                     if (STB_LAST == '0) begin
                        state_d = S_RUN;
                        stab_d  = '0;
                     end else begin
                        state_d = S_STABLE;
                        stab_d  = SW'(1);
                     end
                  end else if (stab_q == STB_LAST) begin
                     state_d = S_RUN;
                     stab_d  = '0;
                  end else begin
                     stab_d = stab_q + 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (!lock_s) begin
                  state_d = S_HOLD;
                  hold_d  = '0;
                  retry_d = '0;
               end
            end
            S_FAULT: begin
               state_d = S_FAULT;
            end
            default: begin
               state_d = S_HOLD;
               hold_d  = '0;
            end
         endcase
      end
   end

   always_comb begin
      resetb_d = (state_d != S_HOLD) && (state_d != S_FAULT);
      run_d    = (state_d == S_RUN);
      fault_d  = (state_d == S_FAULT);
   end

   assign bus.PLL_RESETB  = resetb_q;
   assign bus.SYS_RESETN  = run_q;
   assign bus.LOCKED      = run_q;
   assign bus.FAULT       = fault_q;
   assign bus.RETRY_COUNT = retry_q;

endmodule
